// File: rtl/arb_sched_pkg.sv
// rtl/arb_sched_pkg.sv - shared types and helpers for the round-robin arbiter
package arb_sched_pkg;

   localparam int NUM_REQ = 4;
   localparam int ID_W    = 2;

   // S_IDLE=0, S_GNT0..S_GNT3=1..4, S_RECOVER=5; 6 and 7 are illegal
   typedef enum logic [2:0] {
      S_IDLE,
      S_GNT[4],
      S_RECOVER
   } arb_state_t;

   // Requester index owning a grant state; 0 for every non-grant state
   function automatic logic [ID_W-1:0] state_to_id(input arb_state_t s);
      logic [ID_W-1:0] id;
      id = '0;
      case (s)
         S_GNT0:  id = 2'd0;
         S_GNT1:  id = 2'd1;
         S_GNT2:  id = 2'd2;
         S_GNT3:  id = 2'd3;
         default: id = '0;
      endcase
      return id;
   endfunction

   // Grant state for a requester index
   function automatic arb_state_t id_to_state(input logic [ID_W-1:0] id);
      arb_state_t s;
      s = S_GNT0;
      case (id)
         2'd0:    s = S_GNT0;
         2'd1:    s = S_GNT1;
         2'd2:    s = S_GNT2;
         default: s = S_GNT3;
      endcase
      return s;
   endfunction

   // True for any of the four grant states
   function automatic logic is_gnt_state(input arb_state_t s);
      return (s == S_GNT0) || (s == S_GNT1) || (s == S_GNT2) || (s == S_GNT3);
   endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - rotating-priority requester selection
module rr_pick
   import arb_sched_pkg::*;
(
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    last_id,
   output logic               any,
   output logic [ID_W-1:0]    pick
);

   logic [ID_W-1:0] idx;
   logic            found;

   // Scan last_id+1, last_id+2, ... with natural 2-bit wrap; last_id itself is checked last
   always_comb begin
      any   = |req;
      pick  = '0;
      found = 1'b0;
      idx   = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = last_id + ID_W'(k);
         if (!found && req[idx]) begin
            pick  = idx;
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/rr_enum_arbiter.sv
// rtl/rr_enum_arbiter.sv - 4-way round-robin arbiter with hold limit and recovery gap
module rr_enum_arbiter
   import arb_sched_pkg::*;
#(
   parameter int MAX_HOLD = 8
)
(
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_REQ-1:0] req,
   input  logic [NUM_REQ-1:0] done,
   output logic [NUM_REQ-1:0] gnt,
   output logic               gnt_valid,
   output logic [ID_W-1:0]    gnt_id,
   output logic               timeout,
   output logic [2:0]         state_o
);

   localparam int CNT_W = $clog2(MAX_HOLD + 1);
   localparam logic [CNT_W-1:0] HOLD_SAT  = CNT_W'(MAX_HOLD);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

   arb_state_t         state_q, state_d;
   logic [ID_W-1:0]    last_id_q, last_id_d;
   logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;
   logic [NUM_REQ-1:0] gnt_q, gnt_d;
   logic               gnt_valid_q, gnt_valid_d;
   logic [ID_W-1:0]    gnt_id_q, gnt_id_d;
   logic               timeout_q, timeout_d;

   logic               pick_any;
   logic [ID_W-1:0]    pick_id;
   logic [ID_W-1:0]    cur_id;
   logic               release_now;

   rr_pick u_pick (
      .req     (req),
      .last_id (last_id_q),
      .any     (pick_any),
      .pick    (pick_id)
   );

   // State, pointer, counter and registered outputs; reset kills any grant immediately
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         last_id_q   <= 2'd3;
         hold_cnt_q  <= '0;
         gnt_q       <= '0;
         gnt_valid_q <= 1'b0;
         gnt_id_q    <= '0;
         timeout_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         last_id_q   <= last_id_d;
         hold_cnt_q  <= hold_cnt_d;
         gnt_q       <= gnt_d;
         gnt_valid_q <= gnt_valid_d;
         gnt_id_q    <= gnt_id_d;
         timeout_q   <= timeout_d;
      end
   end

   // Next-state: grant from idle, release or revoke from a grant, one recovery cycle
   always_comb begin
      state_d     = state_q;
      last_id_d   = last_id_q;
      hold_cnt_d  = hold_cnt_q;
      timeout_d   = 1'b0;
      cur_id      = state_to_id(state_q);
      release_now = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (pick_any) begin
               state_d    = id_to_state(pick_id);
               last_id_d  = pick_id;
               hold_cnt_d = '0;
            end
         end
         S_GNT0, S_GNT1, S_GNT2, S_GNT3: begin
            release_now = done[cur_id] || !req[cur_id];
            if (hold_cnt_q != HOLD_SAT) begin
               hold_cnt_d = hold_cnt_q + 1'b1;
            end
            if (release_now) begin
               state_d = S_RECOVER;
            end else if (hold_cnt_q == HOLD_LAST) begin
               state_d   = S_RECOVER;
               timeout_d = 1'b1;
            end
         end
         S_RECOVER: state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
   end

   // Output decode from the next state so outputs track state_q cycle for cycle
   always_comb begin
      gnt_d       = '0;
      gnt_valid_d = 1'b0;
      gnt_id_d    = '0;
      if (is_gnt_state(state_d)) begin
         gnt_valid_d = 1'b1;
         gnt_id_d    = state_to_id(state_d);
         gnt_d       = NUM_REQ'(1) << state_to_id(state_d);
      end
   end

   assign gnt       = gnt_q;
   assign gnt_valid = gnt_valid_q;
   assign gnt_id    = gnt_id_q;
   assign timeout   = timeout_q;
   assign state_o   = state_q;

endmodule

// File: tb/tb_rr_enum_arbiter.sv
// tb/tb_rr_enum_arbiter.sv - self-checking bench for rr_enum_arbiter
module tb_rr_enum_arbiter;

   localparam int MAX_HOLD = 8;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] req = 4'b0000;
   logic [3:0] done = 4'b0000;
   logic [3:0] gnt;
   logic       gnt_valid;
   logic [1:0] gnt_id;
   logic       timeout;
   logic [2:0] state_o;

   int n_vec = 0;
   int n_err = 0;

   rr_enum_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .done      (done),
      .gnt       (gnt),
      .gnt_valid (gnt_valid),
      .gnt_id    (gnt_id),
      .timeout   (timeout),
      .state_o   (state_o)
   );

   always #5 clk = ~clk;

   // Reference model: mode 0 idle, 1 granted, 2 recovering; held counts grant cycles so far
   int m_mode, m_owner, m_held, m_last;
   logic m_to;

   function automatic int model_pick(input logic [3:0] r, input int last);
      int p;
      p = -1;
      for (int k = 1; k <= 4; k++) begin
         if (p < 0 && r[(last + k) % 4]) p = (last + k) % 4;
      end
      return p;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_mode <= 0; m_owner <= 0; m_held <= 0; m_last <= 3; m_to <= 1'b0;
      end else begin
         m_to <= 1'b0;
         case (m_mode)
            0: if (req != 4'b0000) begin
               m_mode  <= 1;
               m_owner <= model_pick(req, m_last);
               m_last  <= model_pick(req, m_last);
               m_held  <= 1;
            end
            1: if (done[m_owner] || !req[m_owner]) begin
               m_mode <= 2;
            end else if (m_held == MAX_HOLD) begin
               m_mode <= 2;
               m_to   <= 1'b1;
            end else begin
               m_held <= m_held + 1;
            end
            default: m_mode <= 0;
         endcase
      end
   end

   task automatic compare(input string name, input logic [10:0] act, input logic [10:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got gnt=%b vld=%b id=%0d to=%b st=%0d, expected gnt=%b vld=%b id=%0d to=%b st=%0d",
                  name, act[10:7], act[6], act[5:4], act[3], act[2:0],
                  exp[10:7], exp[6], exp[5:4], exp[3], exp[2:0]);
      end
   endtask

   task automatic check_now(input string name, input logic [3:0] eg, input logic [1:0] eid,
                            input logic [2:0] es, input logic eto);
      compare(name, {gnt, gnt_valid, gnt_id, timeout, state_o}, {eg, (eg != 4'b0000), eid, eto, es});
   endtask

   // Apply inputs, clock once, check just after the edge
   task automatic step(input logic [3:0] r, input logic [3:0] d, input logic [3:0] eg,
                       input logic [1:0] eid, input logic [2:0] es, input logic eto, input string name);
      req  = r;
      done = d;
      @(posedge clk);
      #1;
      check_now(name, eg, eid, es, eto);
   endtask

   task automatic check_model(input string name);
      logic [3:0] eg;
      logic [1:0] eid;
      logic [2:0] es;
      eg  = (m_mode == 1) ? (4'b0001 << m_owner) : 4'b0000;
      eid = (m_mode == 1) ? 2'(m_owner) : 2'd0;
      es  = (m_mode == 0) ? 3'd0 : (m_mode == 1) ? 3'(m_owner + 1) : 3'd5;
      check_now(name, eg, eid, es, m_to);
   endtask

   typedef struct {
      logic [3:0] r;
      logic [3:0] d;
      logic [3:0] eg;
      logic [1:0] eid;
      logic [2:0] es;
      logic       eto;
   } vec_t;

   vec_t tbl[20];
   logic [3:0] rnd_req;

   initial begin
      tbl[0]  = '{4'b0001, 4'b0000, 4'b0001, 2'd0, 3'd1, 1'b0};
      tbl[1]  = '{4'b0001, 4'b0001, 4'b0000, 2'd0, 3'd5, 1'b0};
      tbl[2]  = '{4'b0000, 4'b0000, 4'b0000, 2'd0, 3'd0, 1'b0};
      tbl[3]  = '{4'b1111, 4'b0000, 4'b0010, 2'd1, 3'd2, 1'b0};
      tbl[4]  = '{4'b1111, 4'b0010, 4'b0000, 2'd0, 3'd5, 1'b0};
      tbl[5]  = '{4'b1111, 4'b0000, 4'b0000, 2'd0, 3'd0, 1'b0};
      tbl[6]  = '{4'b1111, 4'b0000, 4'b0100, 2'd2, 3'd3, 1'b0};
      tbl[7]  = '{4'b1111, 4'b0100, 4'b0000, 2'd0, 3'd5, 1'b0};
      tbl[8]  = '{4'b1111, 4'b0000, 4'b0000, 2'd0, 3'd0, 1'b0};
      tbl[9]  = '{4'b1111, 4'b0000, 4'b1000, 2'd3, 3'd4, 1'b0};
      tbl[10] = '{4'b1111, 4'b1000, 4'b0000, 2'd0, 3'd5, 1'b0};
      tbl[11] = '{4'b1111, 4'b0000, 4'b0000, 2'd0, 3'd0, 1'b0};
      tbl[12] = '{4'b1111, 4'b0000, 4'b0001, 2'd0, 3'd1, 1'b0};
      tbl[13] = '{4'b1111, 4'b0010, 4'b0001, 2'd0, 3'd1, 1'b0};
      tbl[14] = '{4'b1110, 4'b0000, 4'b0000, 2'd0, 3'd5, 1'b0};
      tbl[15] = '{4'b0000, 4'b0000, 4'b0000, 2'd0, 3'd0, 1'b0};
      tbl[16] = '{4'b0010, 4'b0000, 4'b0010, 2'd1, 3'd2, 1'b0};
      tbl[17] = '{4'b0010, 4'b1000, 4'b0010, 2'd1, 3'd2, 1'b0};
      tbl[18] = '{4'b0000, 4'b0000, 4'b0000, 2'd0, 3'd5, 1'b0};
      tbl[19] = '{4'b0000, 4'b0000, 4'b0000, 2'd0, 3'd0, 1'b0};

      #12;
      check_now("reset_state", 4'b0000, 2'd0, 3'd0, 1'b0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 20; i++) begin
         step(tbl[i].r, tbl[i].d, tbl[i].eg, tbl[i].eid, tbl[i].es, tbl[i].eto,
              $sformatf("table_%0d", i));
      end

      // Hold limit with req[3] also pending: revoke 2, then hand over to 3
      step(4'b1100, 4'b0000, 4'b0100, 2'd2, 3'd3, 1'b0, "to_a_grant");
      for (int i = 1; i < MAX_HOLD; i++)
         step(4'b1100, 4'b0000, 4'b0100, 2'd2, 3'd3, 1'b0, $sformatf("to_a_hold_%0d", i));
      step(4'b1100, 4'b0000, 4'b0000, 2'd0, 3'd5, 1'b1, "to_a_revoke");
      step(4'b1100, 4'b0000, 4'b0000, 2'd0, 3'd0, 1'b0, "to_a_idle");
      step(4'b1100, 4'b0000, 4'b1000, 2'd3, 3'd4, 1'b0, "to_a_next3");
      step(4'b0000, 4'b0000, 4'b0000, 2'd0, 3'd5, 1'b0, "to_a_rel");
      step(4'b0000, 4'b0000, 4'b0000, 2'd0, 3'd0, 1'b0, "to_a_idle2");

      // Hold limit with only req[2]: regranted to 2, then done lands on the limit cycle
      step(4'b0100, 4'b0000, 4'b0100, 2'd2, 3'd3, 1'b0, "to_b_grant");
      for (int i = 1; i < MAX_HOLD; i++)
         step(4'b0100, 4'b0000, 4'b0100, 2'd2, 3'd3, 1'b0, $sformatf("to_b_hold_%0d", i));
      step(4'b0100, 4'b0000, 4'b0000, 2'd0, 3'd5, 1'b1, "to_b_revoke");
      step(4'b0100, 4'b0000, 4'b0000, 2'd0, 3'd0, 1'b0, "to_b_idle");
      step(4'b0100, 4'b0000, 4'b0100, 2'd2, 3'd3, 1'b0, "to_b_regrant2");
      for (int i = 1; i < MAX_HOLD; i++)
         step(4'b0100, 4'b0000, 4'b0100, 2'd2, 3'd3, 1'b0, $sformatf("to_b_hold2_%0d", i));
      step(4'b0000, 4'b0100, 4'b0000, 2'd0, 3'd5, 1'b0, "done_at_limit");
      step(4'b0000, 4'b0000, 4'b0000, 2'd0, 3'd0, 1'b0, "done_at_limit_idle");

      // Asynchronous reset in the middle of a grant
      step(4'b1000, 4'b0000, 4'b1000, 2'd3, 3'd4, 1'b0, "rst_a_grant");
      #3 rst = 1'b1;
      #1 check_now("rst_a_async", 4'b0000, 2'd0, 3'd0, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      step(4'b1000, 4'b0000, 4'b1000, 2'd3, 3'd4, 1'b0, "rst_a_first3");
      #3 rst = 1'b1;
      #1 check_now("rst_b_async", 4'b0000, 2'd0, 3'd0, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      step(4'b1001, 4'b0000, 4'b0001, 2'd0, 3'd1, 1'b0, "rst_b_first0");

      // Randomised traffic against the reference model
      rnd_req = 4'b1001;
      for (int i = 0; i < 3000; i++) begin
         for (int b = 0; b < 4; b++)
            if ($urandom_range(0, 7) == 0) rnd_req[b] = ~rnd_req[b];
         req  = rnd_req;
         done = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'b0000;
         @(posedge clk);
         #1;
         check_model($sformatf("rand_%0d", i));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
